sw_input_port: RTL and testbench
================================

// Module: sw_input_port
// PURPOSE
//   Input-side counterpart of the LED output path: brings 8 raw board switches into the
//   processor core's clock domain. Synchronises and debounces each switch, latches rising
//   edges as sticky pending bits and raises an interrupt line. The core reads state or
//   pending bits through a one-cycle-latency read port. Sits beside the core in the top level,
//   opposite the LED0..LED7 outputs.
// PARAMETERS
//   WIDTH           8   number of switch inputs
//   SAMPLE_DIV      4   clk cycles per debounce sample tick (>=1)
//   STABLE_SAMPLES  3   consecutive differing samples needed to accept a new level (>=1)
// PORTS
//   clk       in   1      system clock, rising edge
//   rst       in   1      synchronous, active-high reset
//   sw_raw    in   WIDTH  asynchronous switch levels
//   rd_en     in   1      read strobe from core, one cycle per read
//   rd_sel    in   1      0: debounced level, 1: rise-pending bits (read-to-clear)
//   rd_data   out  WIDTH  read result, valid while rd_valid=1
//   rd_valid  out  1      high exactly one cycle after each rd_en
//   sw_state  out  WIDTH  debounced switch levels, always visible
//   irq       out  1      OR of all pending bits
// BEHAVIOUR
//   Reset: sync flops, sample counter, per-bit counters, sw_state, pending, rd_data,
//     rd_valid and irq all 0. Reset mid-debounce discards partial counts.
//   Synchroniser: 2 flops per bit; sync = second stage.
//   Tick: counter 0..SAMPLE_DIV-1, wraps; tick=1 in the cycle the count is SAMPLE_DIV-1.
//   Per-bit debounce, evaluated only on tick:
//     sync==sw_state -> cnt<=0.
//     sync!=sw_state and cnt==STABLE_SAMPLES-1 -> sw_state<=sync, cnt<=0.
//     otherwise -> cnt<=cnt+1.
//     cnt width = clog2(STABLE_SAMPLES)+1; cnt never exceeds STABLE_SAMPLES-1.
//   Latency raw->sw_state: 2 + STABLE_SAMPLES*SAMPLE_DIV cycles worst case, plus up to
//     SAMPLE_DIV-1 cycles of tick alignment.
//   Edge capture: sw_state bit 0->1 sets pending bit in the same cycle sw_state updates.
//     Falling edges never set pending.
//   Read: rd_en=1 in cycle N -> rd_valid=1 and rd_data registered in N+1.
//     rd_data = sw_state (sel=0) or pending (sel=1), sampled in cycle N.
//     sel=1 clears in N+1 exactly the pending bits returned.
//     A rise in cycle N sets its bit in N+1 and wins over the clear. No event is lost.
//     rd_valid=0 -> rd_data holds its last value.
//     Back-to-back rd_en gives one rd_valid per strobe.
//   irq registered: irq = |pending, one cycle after pending changes.
// STRUCTURE
//   Shared package sw_io_pkg: SW_WIDTH=8, RD_SEL_LEVEL=0, RD_SEL_PEND=1.
//   Sub-module sw_debounce_bit (clk, rst, tick, din, dout): sync pair + counter,
//     instantiated WIDTH times via generate.
//   Tick counter, pending register and read port stay in the top module.
// TESTING  (SAMPLE_DIV=4, STABLE_SAMPLES=3)
//   1. rst=1 for 3 cycles, sw_raw=8'hFF -> sw_state, rd_data, rd_valid, irq all 0 while rst=1.
//   2. sw_raw=8'h01 held -> sw_state=8'h01 within 17 cycles; pending=8'h01; irq=1 one cycle later.
//   3. bit3 high for 6 cycles then low -> sw_state bit3 stays 0, pending unchanged.
//   4. rd_en with rd_sel=1 -> next cycle rd_valid=1, rd_data=8'h01; pending=0; irq=0 one cycle later.
//   5. bit5 rise lands in the read-clear cycle -> rd_data excludes bit5, pending=8'h20 afterwards.
//   6. rst pulsed while bit7 is mid-count -> counters cleared; bit7 needs a full
//      3-sample window again before sw_state bit7=1.

Source files
------------

// File: rtl/sw_io_pkg.sv
// rtl/sw_io_pkg.sv - shared constants for the switch input port
package sw_io_pkg;

  localparam int   SW_WIDTH     = 8;
  localparam logic RD_SEL_LEVEL = 1'b0;
  localparam logic RD_SEL_PEND  = 1'b1;

endpackage

// File: rtl/sw_debounce_bit.sv
// rtl/sw_debounce_bit.sv - two-flop synchroniser plus tick-driven debounce for one switch
module sw_debounce_bit #(
  parameter int STABLE_SAMPLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int             CW       = $clog2(STABLE_SAMPLES) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_SAMPLES - 1);

  logic          sync1_q, sync2_q;
  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick) begin
      if (sync2_q == state_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        state_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = state_q;
  // Rise is taken from the next state so pending can set on the same edge as dout.
  assign rise = state_d & ~state_q;

endmodule

// File: rtl/sw_input_port.sv
// rtl/sw_input_port.sv - debounced switch port with sticky rise-pending bits, irq and read port
module sw_input_port
  import sw_io_pkg::*;
#(
  parameter int WIDTH          = SW_WIDTH,
  parameter int SAMPLE_DIV     = 4,
  parameter int STABLE_SAMPLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             rd_en,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [WIDTH-1:0] sw_state,
  output logic             irq
);

  localparam int            DW       = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

  logic [DW-1:0]    div_q, div_d;
  logic             tick;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] pend_q, pend_d, pend_clr;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q;
  logic             irq_q;

  assign tick = (div_q == DIV_LAST);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_bit (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .din  (sw_raw[i]),
      .dout (sw_state[i]),
      .rise (rise[i])
    );
  end

  always_comb begin
    div_d     = tick ? '0 : div_q + 1'b1;
    pend_clr  = '0;
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if (rd_sel == RD_SEL_PEND) begin
        rd_data_d = pend_q;
        pend_clr  = pend_q;
      end else begin
        rd_data_d = sw_state;
      end
    end
    // A rise coinciding with a clear survives: only bits actually returned are cleared.
    pend_d = (pend_q & ~pend_clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      pend_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      pend_q     <= pend_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      irq_q      <= |pend_q;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_sw_input_port.sv
// tb/tb_sw_input_port.sv - scoreboard bench for sw_input_port with a cycle-level reference model
module tb_sw_input_port;

  localparam int W  = 8;
  localparam int SD = 4;
  localparam int SS = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw_raw;
  logic         rd_en;
  logic         rd_sel;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic [W-1:0] sw_state;
  logic         irq;

  always #5 clk = ~clk;

  sw_input_port #(
    .WIDTH          (W),
    .SAMPLE_DIV     (SD),
    .STABLE_SAMPLES (SS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_raw   (sw_raw),
    .rd_en    (rd_en),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .sw_state (sw_state),
    .irq      (irq)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level is accepted after SS consecutive differing samples,
  // samples taken every SD-th cycle after reset from the input as it was two cycles earlier.
  logic [W-1:0] hist[$];
  int           m_idx;
  int           streak[W];
  logic [W-1:0] m_state, m_pend, m_new, m_smp, m_rise, m_clr, m_d, m_rd_last;
  logic         m_irq, m_rdv;
  logic [W-1:0] sb[$];

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      sb.delete();
      m_idx = 0;
      foreach (streak[b]) streak[b] = 0;
      m_state   = '0;
      m_pend    = '0;
      m_irq     = 1'b0;
      m_rdv     = 1'b0;
      m_rd_last = '0;
    end else begin
      m_smp = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
      m_new = m_state;
      if (m_idx % SD == SD - 1) begin
        for (int b = 0; b < W; b++) begin
          if (m_smp[b] != m_state[b]) begin
            streak[b]++;
            if (streak[b] == SS) begin
              m_new[b]  = m_smp[b];
              streak[b] = 0;
            end
          end else begin
            streak[b] = 0;
          end
        end
      end
      m_rise = m_new & ~m_state;
      m_irq  = |m_pend;
      m_rdv  = rd_en;
      m_clr  = '0;
      if (rd_en) begin
        m_d = rd_sel ? m_pend : m_state;
        sb.push_back(m_d);
        m_rd_last = m_d;
        if (rd_sel) m_clr = m_pend;
      end
      m_pend  = (m_pend & ~m_clr) | m_rise;
      m_state = m_new;
      hist.push_back(sw_raw);
      m_idx++;
    end
  end

  logic [W-1:0] mon_exp;
  always @(negedge clk) begin
    chk("sw_state", sw_state, m_state);
    chk("irq", irq, m_irq);
    chk("rd_valid", rd_valid, m_rdv);
    if (rd_valid === 1'b1) begin
      chk("rd_queue_depth", sb.size(), 1);
      if (sb.size() > 0) begin
        mon_exp = sb.pop_front();
        chk("rd_data", rd_data, mon_exp);
      end
    end else begin
      chk("rd_hold", rd_data, m_rd_last);
    end
  end

  task automatic do_read(input logic sel, output logic [W-1:0] d, output logic v);
    rd_en  = 1'b1;
    rd_sel = sel;
    @(negedge clk);
    rd_en = 1'b0;
    d = rd_data;
    v = rd_valid;
  endtask

  int           n;
  logic [W-1:0] d;
  logic         v;

  initial begin
    rst    = 1'b1;
    sw_raw = 8'hFF;
    rd_en  = 1'b0;
    rd_sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_sw_state", sw_state, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_irq", irq, 0);

    sw_raw = 8'h01;
    rst    = 1'b0;
    n = 0;
    while (sw_state[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t2_latency", n, 12);
    chk("t2_irq_lags", irq, 0);
    @(negedge clk);
    chk("t2_irq", irq, 1);

    sw_raw[3] = 1'b1;
    repeat (6) @(negedge clk);
    sw_raw[3] = 1'b0;
    repeat (20) @(negedge clk);
    chk("t3_glitch_state", sw_state[3], 0);
    chk("t3_irq_kept", irq, 1);

    do_read(1'b1, d, v);
    chk("t4_valid", v, 1);
    chk("t4_data", d, 8'h01);
    chk("t4_irq_lag", irq, 1);
    @(negedge clk);
    chk("t4_irq_clear", irq, 0);

    sw_raw[5] = 1'b1;
    rd_en     = 1'b1;
    rd_sel    = 1'b1;
    n = 0;
    while (sw_state[5] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    rd_en = 1'b0;
    chk("t5_rise_seen", sw_state[5], 1);
    chk("t5_excl_bit5", rd_data, 8'h00);
    @(negedge clk);
    chk("t5_irq", irq, 1);
    do_read(1'b1, d, v);
    chk("t5_pending", d, 8'h20);

    do_read(1'b0, d, v);
    chk("level_read", d, 8'h21);

    sw_raw[7] = 1'b1;
    repeat (9) @(negedge clk);
    chk("t6_not_yet", sw_state[7], 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_reset_state", sw_state, 0);
    rst = 1'b0;
    n = 0;
    while (sw_state[7] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t6_full_window", n, 12);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0) sw_raw[$urandom_range(W-1)] ^= 1'b1;
      rd_en  = ($urandom_range(2) == 0);
      rd_sel = $urandom_range(1) == 1;
      rst    = ($urandom_range(1499) == 0);
      @(negedge clk);
    end
    rst   = 1'b0;
    rd_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
